// File: rtl/turbo_pkg.sv
// Shared types for the turbo LLR frame buffer: default LLR width, read-side FSM
// states and the packed {sys, par1, par2} triplet layout used on the read port.
package turbo_pkg;

  localparam int unsigned LLR_W_DEF = 6;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_OFFER = 2'd1,
    R_BUSY  = 2'd2
  } rd_state_e;

  typedef struct packed {
    logic [LLR_W_DEF-1:0] sys;
    logic [LLR_W_DEF-1:0] par1;
    logic [LLR_W_DEF-1:0] par2;
  } llr_triplet_t;

endpackage

// File: rtl/turbo_llr_bank.sv
// One K-entry frame bank: single write port, synchronous read port.
// Contents are not reset; the read register only updates when enabled.
module turbo_llr_bank
  import turbo_pkg::*;
#(
  parameter int unsigned K      = 40,
  parameter int unsigned DATA_W = 18,
  localparam int unsigned ADDR_W = $clog2(K)
) (
  input  logic              clk_p_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [K];
  logic [DATA_W-1:0] rd_data_q;

  // RAM write and registered read; rd_en_i is low for out-of-range addresses.
  always_ff @(posedge clk_p_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/turbo_llr_frame_buffer.sv
// Ping-pong channel-LLR frame buffer feeding the turbo decoder. Streams of
// {sys, par1, par2} triplets are packed into K-symbol frames in alternating
// banks; each full bank is offered to the decoder and served for random reads
// until the decoder releases it.
// Optional build macro: TURBO_LLR_SAT_EN -- stores the most negative LLR as
// its symmetric neighbour so the SISO can negate any stored value safely.
module turbo_llr_frame_buffer
  import turbo_pkg::*;
#(
  parameter int unsigned K      = 40,
  parameter int unsigned LLR_W  = LLR_W_DEF,
  localparam int unsigned ADDR_W = $clog2(K)
) (
  input  logic                 clk_p_i,
  input  logic                 reset_n_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [LLR_W-1:0]     in_sys_i,
  input  logic [LLR_W-1:0]     in_par1_i,
  input  logic [LLR_W-1:0]     in_par2_i,
  input  logic                 in_last_i,
  output logic                 frame_valid_o,
  input  logic                 dec_start_i,
  input  logic                 dec_done_i,
  input  logic [ADDR_W-1:0]    rd_addr_i,
  output logic [3*LLR_W-1:0]   rd_data_o,
  output logic                 err_o,
  output logic [15:0]          frame_cnt_o
);

  localparam int unsigned DATA_W = 3 * LLR_W;

`ifdef TURBO_LLR_SAT_EN
  localparam logic [LLR_W-1:0] LlrMin    = {1'b1, {(LLR_W-1){1'b0}}};
  localparam logic [LLR_W-1:0] LlrMinSat = LlrMin + LLR_W'(1);
`endif

  function automatic logic [LLR_W-1:0] store_llr(input logic [LLR_W-1:0] x);
`ifdef TURBO_LLR_SAT_EN
    if (x == LlrMin) begin
      return LlrMinSat;
    end
`endif
    return x;
  endfunction

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  rd_state_e         rd_state_q, rd_state_d;
  logic              err_q, err_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              rd_sel_q, rd_ok_q;

  logic              accept;
  logic              wr_close;
  logic              rd_en;
  logic [1:0]        bank_wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] bank_rd_data [2];

  assign in_ready_o = ~full_q[wr_bank_q];
  assign accept     = in_valid_i & in_ready_o;
  assign wr_close   = accept & (wr_ptr_q == ADDR_W'(K - 1));
  assign wr_data    = {store_llr(in_sys_i), store_llr(in_par1_i), store_llr(in_par2_i)};
  assign bank_wr_en = {accept & wr_bank_q, accept & ~wr_bank_q};
  assign rd_en      = 32'(rd_addr_i) < K;

  // Write side: advance the pointer, close frames by count, flag framing errors.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    wr_bank_d = wr_bank_q;
    err_d     = err_q;
    if (accept) begin
      // in_last_i must coincide exactly with the closing symbol.
      if (in_last_i != wr_close) begin
        err_d = 1'b1;
      end
      if (wr_close) begin
        wr_ptr_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
    end
  end

  // Read FSM plus bank-full bookkeeping; a close and a release hit different banks.
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_bank_d   = rd_bank_q;
    frame_cnt_d = frame_cnt_q;
    full_d      = full_q;
    if (wr_close) begin
      full_d[wr_bank_q] = 1'b1;
    end
    unique case (rd_state_q)
      R_IDLE: begin
        if (full_q[rd_bank_q]) begin
          rd_state_d = R_OFFER;
        end
      end
      R_OFFER: begin
        if (dec_start_i) begin
          rd_state_d = R_BUSY;
        end
      end
      R_BUSY: begin
        if (dec_done_i) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          frame_cnt_d       = frame_cnt_q + 16'd1;
          rd_state_d        = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // State registers, including the read-side select/valid pipeline stage.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      full_q      <= '0;
      rd_state_q  <= R_IDLE;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      rd_sel_q    <= 1'b0;
      rd_ok_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      full_q      <= full_d;
      rd_state_q  <= rd_state_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      rd_sel_q    <= rd_bank_q;
      rd_ok_q     <= rd_en;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    turbo_llr_bank #(
      .K      (K),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk_p_i   (clk_p_i),
      .wr_en_i   (bank_wr_en[b]),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (wr_data),
      .rd_en_i   (rd_en),
      .rd_addr_i (rd_addr_i),
      .rd_data_o (bank_rd_data[b])
    );
  end

  // rd_ok_q masks out-of-range addresses and the unreset RAM output after reset.
  assign rd_data_o     = rd_ok_q ? bank_rd_data[rd_sel_q] : '0;
  assign frame_valid_o = (rd_state_q == R_OFFER);
  assign err_o         = err_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule
